memwb_stage: RTL and testbench

Parametrised MEM/WB pipeline stage with elastic valid/ready handshake, a one-entry skid buffer, synchronous flush and x0-write squashing. Sits between the memory stage and writeback. It lets writeback back-pressure the pipe without a combinational ready path, and it never presents a bubble as a register write. Field widths are parameters, so the same block serves other stage boundaries.

---
 rtl/memwb_stage.sv | 155 +++++++++++++++
 tb/tb_memwb_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/memwb_stage.sv
// ---------------------------------------------------------------------------
// memwb_stage
//
// MEM/WB pipeline register with an elastic valid/ready handshake and a
// one-entry skid buffer. Writeback can stall the pipe without any
// combinational path from out_ready back to in_ready. A synchronous flush
// discards everything held. Writes to register x0 can be squashed on capture
// so that a bubble or an x0 destination is never presented as a real
// register-file write.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   in_valid         MEM stage presents a beat
//   in_ready         stage can accept a beat (registered state only)
//   in_ctrl          writeback control field
//   in_mem_data      load data
//   in_alu_result    ALU result
//   in_rd_addr       destination register
//   flush            discard all held beats
//   out_valid        a WB beat is present
//   out_ready        writeback accepts the beat
//   out_ctrl         held control, forced to zero when out_valid is low
//   out_mem_data     held load data
//   out_alu_result   held ALU result
//   out_rd_addr      held destination register
//   count            occupancy, 0..2
// ---------------------------------------------------------------------------
module memwb_stage #(
    parameter int CTRL_W    = 4,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int WE_BIT    = 0,
    parameter int SQUASH_X0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic [1:0]        count
);

    // The state encoding is the occupancy itself, so count falls straight out.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] alu_result;
        logic [ADDR_W-1:0] rd_addr;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t cap;

    logic accept;
    logic drain;

    // Handshake flags decode from the state register only, which keeps
    // out_ready off the in_ready timing path.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;
    assign count     = state_q;

    // A held entry with stale contents must never look like a write.
    assign out_ctrl       = out_valid ? main_q.ctrl : '0;
    assign out_mem_data   = main_q.mem_data;
    assign out_alu_result = main_q.alu_result;
    assign out_rd_addr    = main_q.rd_addr;

    // Capture transform: an x0 destination has its write enable cleared so
    // the register file never sees a write to the hardwired zero register.
    always_comb begin
        cap.ctrl       = in_ctrl;
        cap.mem_data   = in_mem_data;
        cap.alu_result = in_alu_result;
        cap.rd_addr    = in_rd_addr;
        if ((SQUASH_X0 != 0) && (in_rd_addr == '0)) begin
            cap.ctrl[WE_BIT] = 1'b0;
        end
    end

    // Next-state and entry steering. New beats go to main whenever main is
    // free or being drained in the same cycle; otherwise they park in skid.
    // Draining from FULL promotes skid into main to keep FIFO order.
    // Flush overrides the occupancy but leaves payload contents alone.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    main_d  = cap;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    main_d = cap;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = cap;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
    end

    // State and payload registers; reset clears everything, including the
    // payload, so the outputs read zero straight after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_memwb_stage.sv
// ---------------------------------------------------------------------------
// tb_memwb_stage
//
// Directed-vector bench for memwb_stage. The driver pushes the hand-computed
// expected beat into a queue whenever a beat is accepted; an independent
// monitor pops and compares whenever the DUT completes an output transfer.
// A second instance with SQUASH_X0 = 0 shares the inputs so the x0 squash
// can be compared against the unsquashed behaviour.
// ---------------------------------------------------------------------------
module tb_memwb_stage;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] memData;
        logic [31:0] aluResult;
        logic [4:0]  rdAddr;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [31:0] in_mem_data;
    logic [31:0] in_alu_result;
    logic [4:0]  in_rd_addr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [31:0] out_mem_data;
    logic [31:0] out_alu_result;
    logic [4:0]  out_rd_addr;
    logic [1:0]  count;

    logic        nsInReady;
    logic        nsOutValid;
    logic [3:0]  nsOutCtrl;
    logic [31:0] nsOutMemData;
    logic [31:0] nsOutAluResult;
    logic [4:0]  nsOutRdAddr;
    logic [1:0]  nsCount;

    beat_t expQ[$];
    beat_t monBeat;
    beat_t gotBeat;
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    memwb_stage #(.CTRL_W(4), .DATA_W(32), .ADDR_W(5), .WE_BIT(0), .SQUASH_X0(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_mem_data(in_mem_data),
        .in_alu_result(in_alu_result), .in_rd_addr(in_rd_addr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_mem_data(out_mem_data),
        .out_alu_result(out_alu_result), .out_rd_addr(out_rd_addr),
        .count(count)
    );

    memwb_stage #(.CTRL_W(4), .DATA_W(32), .ADDR_W(5), .WE_BIT(0), .SQUASH_X0(0)) dutNoSquash (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(nsInReady),
        .in_ctrl(in_ctrl), .in_mem_data(in_mem_data),
        .in_alu_result(in_alu_result), .in_rd_addr(in_rd_addr),
        .flush(flush),
        .out_valid(nsOutValid), .out_ready(out_ready),
        .out_ctrl(nsOutCtrl), .out_mem_data(nsOutMemData),
        .out_alu_result(nsOutAluResult), .out_rd_addr(nsOutRdAddr),
        .count(nsCount)
    );

    // Monitor: every completed output transfer must match the oldest
    // expected beat; a transfer with nothing expected is itself an error.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            gotBeat.ctrl      = out_ctrl;
            gotBeat.memData   = out_mem_data;
            gotBeat.aluResult = out_alu_result;
            gotBeat.rdAddr    = out_rd_addr;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_beat got ctrl=%h mem=%h alu=%h rd=%0d required no beat",
                         out_ctrl, out_mem_data, out_alu_result, out_rd_addr);
            end else begin
                monBeat = expQ.pop_front();
                if (gotBeat !== monBeat) begin
                    errors++;
                    $display("[TB] FAIL beat got ctrl=%h mem=%h alu=%h rd=%0d required ctrl=%h mem=%h alu=%h rd=%0d",
                             gotBeat.ctrl, gotBeat.memData, gotBeat.aluResult, gotBeat.rdAddr,
                             monBeat.ctrl, monBeat.memData, monBeat.aluResult, monBeat.rdAddr);
                end
            end
        end
    end

    // Compare one observed value with its hand-computed requirement.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s got %h required %h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs (called just after a rising edge), record the
    // expected beat if it is accepted, and return just after the next edge.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] m,
                                 input logic [31:0] a, input logic [4:0] r,
                                 input logic [3:0] expCtrl, input logic fl);
        beat_t tmp;
        in_valid      = v;
        in_ctrl       = c;
        in_mem_data   = m;
        in_alu_result = a;
        in_rd_addr    = r;
        flush         = fl;
        @(negedge clk);
        if (!rst && !fl && v && in_ready) begin
            tmp.ctrl      = expCtrl;
            tmp.memData   = m;
            tmp.aluResult = a;
            tmp.rdAddr    = r;
            expQ.push_back(tmp);
        end
        @(posedge clk);
        #1;
        if (fl) expQ.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 4'h0, 1'b0);
    endtask

    // Directed sequence: reset, streaming, back-pressure, flush, x0 squash.
    initial begin
        rst           = 1'b1;
        in_valid      = 1'b1;
        in_ctrl       = 4'hF;
        in_mem_data   = 32'hDEAD_BEEF;
        in_alu_result = 32'hCAFE_F00D;
        in_rd_addr    = 5'd9;
        flush         = 1'b0;
        out_ready     = 1'b0;

        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_count", {30'd0, count}, 32'd0);
        checkOutput("rst_out_ctrl", {28'd0, out_ctrl}, 32'd0);
        checkOutput("rst_out_mem_data", out_mem_data, 32'd0);
        checkOutput("rst_out_alu_result", out_alu_result, 32'd0);
        checkOutput("rst_out_rd_addr", {27'd0, out_rd_addr}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_count", {30'd0, count}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        $display("[TB] streaming");
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 4'b0001, 32'hA000_0000 + i, i, 5'd3, 4'b0001, 1'b0);
            checkOutput("stream_count", {30'd0, count}, 32'd1);
            checkOutput("stream_alu", out_alu_result, i);
        end
        idleCycle();
        checkOutput("stream_empty_count", {30'd0, count}, 32'd0);

        $display("[TB] back-pressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b0001, 32'hB000_0011, 32'h11, 5'd1, 4'b0001, 1'b0);
        checkOutput("bp_count_one", {30'd0, count}, 32'd1);
        applyStimulus(1'b1, 4'b0001, 32'hB000_0022, 32'h22, 5'd2, 4'b0001, 1'b0);
        checkOutput("bp_count_full", {30'd0, count}, 32'd2);
        checkOutput("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        checkOutput("bp_main_holds_a", out_alu_result, 32'h11);
        applyStimulus(1'b1, 4'b0001, 32'hB000_0099, 32'h99, 5'd4, 4'b0001, 1'b0);
        checkOutput("bp_full_hold_count", {30'd0, count}, 32'd2);
        checkOutput("bp_full_hold_alu", out_alu_result, 32'h11);
        out_ready = 1'b1;
        idleCycle();
        checkOutput("bp_after_drain_count", {30'd0, count}, 32'd1);
        checkOutput("bp_skid_promoted", out_alu_result, 32'h22);
        checkOutput("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
        idleCycle();
        checkOutput("bp_drained_count", {30'd0, count}, 32'd0);

        $display("[TB] flush");
        out_ready = 1'b0;
        applyStimulus(1'b1, 4'b0001, 32'hC000_0044, 32'h44, 5'd5, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0001, 32'hC000_0055, 32'h55, 5'd6, 4'b0001, 1'b0);
        checkOutput("flush_pre_count", {30'd0, count}, 32'd2);
        applyStimulus(1'b1, 4'b0001, 32'hC000_0033, 32'h33, 5'd7, 4'b0001, 1'b1);
        checkOutput("flush_full_count", {30'd0, count}, 32'd0);
        checkOutput("flush_full_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_full_out_ctrl", {28'd0, out_ctrl}, 32'd0);
        checkOutput("flush_full_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 4'b0001, 32'hC000_0066, 32'h66, 5'd8, 4'b0001, 1'b0);
        applyStimulus(1'b1, 4'b0001, 32'hC000_0077, 32'h77, 5'd9, 4'b0001, 1'b1);
        checkOutput("flush_one_count", {30'd0, count}, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);

        $display("[TB] x0 squash and accept-with-drain");
        applyStimulus(1'b1, 4'b0101, 32'hD000_0001, 32'h101, 5'd0, 4'b0100, 1'b0);
        checkOutput("squash_rd0_ctrl", {28'd0, out_ctrl}, 32'h4);
        checkOutput("nosquash_rd0_ctrl", {28'd0, nsOutCtrl}, 32'h5);
        applyStimulus(1'b1, 4'b0101, 32'hD000_0002, 32'h102, 5'd7, 4'b0101, 1'b0);
        checkOutput("squash_rd7_ctrl", {28'd0, out_ctrl}, 32'h5);
        checkOutput("nosquash_rd7_ctrl", {28'd0, nsOutCtrl}, 32'h5);
        checkOutput("accept_drain_count", {30'd0, count}, 32'd1);
        checkOutput("accept_drain_alu", out_alu_result, 32'h102);
        idleCycle();
        checkOutput("final_count", {30'd0, count}, 32'd0);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
